// File: rtl/uart_frame_tx_if.sv
// Handshake and serial-line bundle for uart_frame_tx.
// The master side supplies the payload and start request; the slave side is the transmitter.
interface uart_frame_tx_if #(
  parameter int DATA_W = 288
);
  logic [DATA_W-1:0] data;
  logic              start;
  logic              ready;
  logic              tx;
  logic              byte_done;
  logic              done;

  modport master (
    output data,
    output start,
    input  ready,
    input  tx,
    input  byte_done,
    input  done
  );

  modport slave (
    input  data,
    input  start,
    output ready,
    output tx,
    output byte_done,
    output done
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Serialises an N-word payload as back-to-back UART bytes (8 data bits, optional parity, 1-2 stops).
// The payload is latched on acceptance, so the source may change data while a frame is in flight.
//
// state | meaning
// IDLE  | line idle high, ready for start
// START | start bit (low) for one bit time
// DATA  | 8 data bits, LSB first
// PAR   | parity bit (only when PARITY != 0)
// STOP  | STOP_BITS high stop bits, then next byte or back to IDLE
`ifndef DEFAULT_CLKS_PER_BIT
`define DEFAULT_CLKS_PER_BIT 16
`endif

module uart_frame_tx #(
  parameter int N              = 9,
  parameter int SIZE           = 32,
  parameter int CLKS_PER_BIT   = `DEFAULT_CLKS_PER_BIT,
  parameter int BYTE_MSB_FIRST = 0,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input logic           clk,
  input logic           rst_n,
  uart_frame_tx_if.slave bus
);

  localparam int DW     = N * SIZE;
  localparam int BPW    = SIZE / 8;
  localparam int NB     = N * BPW;
  localparam int BIT_W  = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NB - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;

  logic [DW-1:0]     ordered;
  logic              bit_tc;
  logic              tx_o;

  // Bytes are rearranged into transmit order at capture, so the shadow just shifts right per byte.
  for (genvar w = 0; w < N; w++) begin : g_word
    for (genvar j = 0; j < BPW; j++) begin : g_byte
      localparam int SRC = (BYTE_MSB_FIRST != 0) ? (BPW - 1 - j) : j;
      assign ordered[w*SIZE + j*8 +: 8] = bus.data[w*SIZE + SRC*8 +: 8];
    end
  end

  assign bit_tc = (bit_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shadow_d   = shadow_q;
    shift_d    = shift_q;
    par_d      = par_q;

    if (state_q != IDLE) begin
      bit_cnt_d = bit_tc ? BIT_LAST : (bit_cnt_q - BIT_W'(1));
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = START;
          bit_cnt_d  = BIT_LAST;
          byte_cnt_d = BYTE_LAST;
          shadow_d   = ordered;
        end
      end
      START: begin
        if (bit_tc) begin
          state_d   = DATA;
          bit_idx_d = 3'd7;
          shift_d   = shadow_q[7:0];
          par_d     = (PARITY == 2) ? ~(^shadow_q[7:0]) : (^shadow_q[7:0]);
          shadow_d  = shadow_q >> 8;
        end
      end
      DATA: begin
        if (bit_tc) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd0) begin
            state_d    = (PARITY != 0) ? PAR : STOP;
            stop_cnt_d = STOP_LAST;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
          end
        end
      end
      PAR: begin
        if (bit_tc) begin
          state_d    = STOP;
          stop_cnt_d = STOP_LAST;
        end
      end
      STOP: begin
        if (bit_tc) begin
          if (stop_cnt_q == 1'b0) begin
            if (byte_cnt_q == '0) begin
              state_d = IDLE;
            end else begin
              state_d    = START;
              byte_cnt_d = byte_cnt_q - BYTE_W'(1);
            end
          end else begin
            stop_cnt_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      byte_cnt_q <= '0;
      shadow_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shadow_q   <= shadow_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
    end
  end

  // tx is decoded from state so that reset drives the line high without waiting for a clock.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
      PAR:     tx_o = par_q;
      default: tx_o = 1'b1;
    endcase
  end

  assign bus.tx        = tx_o;
  assign bus.ready     = (state_q == IDLE);
  assign bus.byte_done = (state_q == STOP) && bit_tc && (stop_cnt_q == 1'b0);
  assign bus.done      = bus.byte_done && (byte_cnt_q == '0);

endmodule
